// File: rtl/mac_operand_loader_pkg.sv
// Shared widths and state encoding for the MAC operand loader.
// Width defaults are common to the MAC and multiplier.
package mac_operand_loader_pkg;
  localparam int DEF_NUM_INPUTS   = 4;
  localparam int DEF_PIXEL_WIDTH  = 10;
  localparam int DEF_WEIGHT_WIDTH = 19;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/mac_operand_loader_if.sv
// Pixel/weight stream handshake into the operand loader.
interface mac_operand_loader_if #(
  parameter int PW = 10,
  parameter int WW = 19
);
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_pixel;
  logic [WW-1:0] in_weight;

  modport master (
    output in_valid, in_pixel, in_weight,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_pixel, in_weight,
    output in_ready
  );
endinterface

// File: rtl/mac_operand_loader_packer.sv
// Fill register: packs accepted pairs into slots, LSB slot first.
module operand_packer #(
  parameter int N  = 4,
  parameter int PW = 10,
  parameter int WW = 19
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            accept_i,
  input  logic [PW-1:0]   pixel_i,
  input  logic [WW-1:0]   weight_i,
  output logic [N*PW-1:0] fill_pix_o,
  output logic [N*WW-1:0] fill_wgt_o,
  output logic            fill_full_o
);
  localparam int CW = $clog2(N + 1);

  logic [CW-1:0]   cnt_q;
  logic [N*PW-1:0] pix_q;
  logic [N*WW-1:0] wgt_q;
  logic            full_q;

  // clear and accept are exclusive: accept needs !full, clear needs full
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      pix_q  <= '0;
      wgt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      if (clear_i) full_q <= 1'b0;
      if (accept_i) begin
        for (int k = 0; k < N; k++) begin
          if (cnt_q == CW'(k)) begin
            pix_q[k*PW +: PW] <= pixel_i;
            wgt_q[k*WW +: WW] <= weight_i;
          end
        end
        if (cnt_q == CW'(N - 1)) begin
          cnt_q  <= '0;
          full_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign fill_pix_o  = pix_q;
  assign fill_wgt_o  = wgt_q;
  assign fill_full_o = full_q;
endmodule

// File: rtl/mac_operand_loader.sv
// Double-buffered stream-to-vector front end for the pipelined MAC.
module mac_operand_loader
  import mac_operand_loader_pkg::*;
#(
  parameter int NUM_INPUTS   = DEF_NUM_INPUTS,
  parameter int PIXEL_WIDTH  = DEF_PIXEL_WIDTH,
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  mac_operand_loader_if.slave                  in_if,
  output logic [NUM_INPUTS*PIXEL_WIDTH-1:0]    out_pixels,
  output logic [NUM_INPUTS*WEIGHT_WIDTH-1:0]   out_weights,
  output logic                                 mac_start,
  input  logic                                 mac_done,
  output logic                                 busy
);
  localparam int PB = NUM_INPUTS * PIXEL_WIDTH;
  localparam int WB = NUM_INPUTS * WEIGHT_WIDTH;

  state_e        state_q, state_d;
  logic [PB-1:0] pix_q, fill_pix;
  logic [WB-1:0] wgt_q, fill_wgt;
  logic          start_q;
  logic          fill_full;
  logic          accept;
  logic          done_ok;
  logic          swap;

  assign in_if.in_ready = !fill_full;
  assign accept  = in_if.in_valid && !fill_full;
  // done is stale while start is high and meaningless when idle
  assign done_ok = (state_q == RUN) && mac_done && !start_q;
  assign swap    = fill_full && ((state_q == IDLE) || done_ok);

  operand_packer #(
    .N  (NUM_INPUTS),
    .PW (PIXEL_WIDTH),
    .WW (WEIGHT_WIDTH)
  ) u_packer (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (swap),
    .accept_i    (accept),
    .pixel_i     (in_if.in_pixel),
    .weight_i    (in_if.in_weight),
    .fill_pix_o  (fill_pix),
    .fill_wgt_o  (fill_wgt),
    .fill_full_o (fill_full)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (swap) state_d = RUN;
      RUN:  if (done_ok && !fill_full) state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q   <= '0;
      wgt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= swap;
      if (swap) begin
        pix_q <= fill_pix;
        wgt_q <= fill_wgt;
      end
    end
  end

  assign out_pixels  = pix_q;
  assign out_weights = wgt_q;
  assign mac_start   = start_q;
endmodule

// File: tb/tb_mac_operand_loader.sv
// Directed bench for mac_operand_loader with a queue-based window model.
module tb_mac_operand_loader;
  import mac_operand_loader_pkg::*;

  localparam int N  = DEF_NUM_INPUTS;
  localparam int PW = DEF_PIXEL_WIDTH;
  localparam int WW = DEF_WEIGHT_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic done_man = 1'b0;
  logic done_auto = 1'b0;
  logic mac_done;
  logic [N*PW-1:0] out_pixels;
  logic [N*WW-1:0] out_weights;
  logic mac_start, busy;
  bit   auto_mac = 0;

  assign mac_done = done_man | done_auto;

  mac_operand_loader_if #(.PW(PW), .WW(WW)) bus ();

  mac_operand_loader dut (
    .clk         (clk),
    .rst         (rst),
    .in_if       (bus),
    .out_pixels  (out_pixels),
    .out_weights (out_weights),
    .mac_start   (mac_start),
    .mac_done    (mac_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int starts = 0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [PW-1:0] p;
    logic [WW-1:0] w;
  } pair_t;

  pair_t       fillq[$];
  bit          m_full = 0;
  bit          m_run = 0;
  bit          m_start = 0;
  logic [N*PW-1:0] m_pix = '0;
  logic [N*WW-1:0] m_wgt = '0;

  initial begin
    bit done_eff, swp, acc;
    forever begin
      @(negedge clk);
      chk("in_ready", bus.in_ready, !m_full);
      chk("busy", busy, m_run);
      chk("mac_start", mac_start, m_start);
      chk("out_pixels", out_pixels, m_pix);
      chk("out_weights", out_weights, m_wgt);
      if (mac_start === 1'b1) starts++;
      // advance to the state after the coming rising edge
      if (rst) begin
        fillq.delete();
        m_full = 0; m_run = 0; m_start = 0;
        m_pix = '0; m_wgt = '0;
      end else begin
        done_eff = m_run && mac_done && !m_start;
        swp = m_full && (!m_run || done_eff);
        acc = bus.in_valid && !m_full;
        m_start = swp;
        if (swp) begin
          for (int k = 0; k < N; k++) begin
            m_pix[k*PW +: PW] = fillq[k].p;
            m_wgt[k*WW +: WW] = fillq[k].w;
          end
          fillq.delete();
          m_full = 0;
          m_run = 1;
        end else if (done_eff) begin
          m_run = 0;
        end
        if (acc) begin
          fillq.push_back({bus.in_pixel, bus.in_weight});
          if (fillq.size() == N) m_full = 1;
        end
      end
    end
  end

  // MAC timing stand-in: done in cycle S+1+N after start in cycle S
  initial begin
    int cd;
    cd = 0;
    forever begin
      @(posedge clk); #2;
      done_auto = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) done_auto = 1'b1;
      end
      if (auto_mac && mac_start === 1'b1) cd = N + 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic push(logic [PW-1:0] p, logic [WW-1:0] w);
    bit took;
    took = 0;
    bus.in_valid  = 1'b1;
    bus.in_pixel  = p;
    bus.in_weight = w;
    for (int t = 0; t < 200 && !took; t++) begin
      took = bus.in_ready;
      cyc(1);
    end
    chk("push_accept", took, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, t;
    bus.in_valid  = 1'b0;
    bus.in_pixel  = '0;
    bus.in_weight = '0;
    cyc(2);
    rst = 1'b0;
    chk("rst_ready", bus.in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pix", out_pixels, '0);
    chk("rst_start", mac_start, 1'b0);

    // done while idle is ignored
    done_man = 1'b1;
    cyc(1);
    done_man = 1'b0;
    chk("idle_done_busy", busy, 1'b0);
    chk("idle_done_start", mac_start, 1'b0);

    // single window
    push(10'h001, 19'h00001);
    push(10'h3FF, 19'h7FFFF);
    push(10'h1FF, 19'h40000);
    push(10'h200, 19'h3FFFF);
    bus.in_valid = 1'b0;
    chk("win1_pre_start", mac_start, 1'b0);
    chk("win1_full", bus.in_ready, 1'b0);
    cyc(1);
    chk("win1_start", mac_start, 1'b1);
    chk("win1_pix", out_pixels, {10'h200, 10'h1FF, 10'h3FF, 10'h001});
    chk("win1_wgt", out_weights,
        {19'h3FFFF, 19'h40000, 19'h7FFFF, 19'h00001});
    chk("win1_busy", busy, 1'b1);
    // done during the start cycle is ignored
    done_man = 1'b1;
    cyc(1);
    done_man = 1'b0;
    chk("start_done_busy", busy, 1'b1);
    chk("start_one_cycle", mac_start, 1'b0);

    // back-to-back: window 2 fills during RUN
    for (int i = 0; i < N; i++) push(PW'(10 + i), WW'(100 + i));
    bus.in_valid = 1'b0;
    chk("b2b_ready_low", bus.in_ready, 1'b0);
    cyc(2);
    chk("b2b_wait_busy", busy, 1'b1);
    chk("b2b_wait_start", mac_start, 1'b0);
    done_man = 1'b1;
    cyc(1);
    done_man = 1'b0;
    chk("b2b_start", mac_start, 1'b1);
    chk("b2b_ready", bus.in_ready, 1'b1);
    chk("b2b_pix", out_pixels, {10'd13, 10'd12, 10'd11, 10'd10});
    chk("b2b_wgt", out_weights, {19'd103, 19'd102, 19'd101, 19'd100});

    // completion with nothing pending returns to idle, outputs hold
    cyc(1);
    done_man = 1'b1;
    cyc(1);
    done_man = 1'b0;
    chk("drain_busy", busy, 1'b0);
    chk("drain_hold", out_pixels, {10'd13, 10'd12, 10'd11, 10'd10});

    // backpressure: valid held across three windows
    auto_mac = 1;
    s0 = starts;
    for (int w = 0; w < 3; w++)
      for (int k = 0; k < N; k++)
        push(PW'(w * 4 + k + 1), WW'(w * 4 + k + 100));
    bus.in_valid = 1'b0;
    t = 0;
    while ((busy || !bus.in_ready) && t < 100) begin
      cyc(1);
      t++;
    end
    chk("bp_drained", busy, 1'b0);
    chk("bp_windows", starts - s0, 3);
    chk("bp_last_pix", out_pixels, {10'd12, 10'd11, 10'd10, 10'd9});
    chk("bp_last_wgt", out_weights, {19'd111, 19'd110, 19'd109, 19'd108});
    auto_mac = 0;
    cyc(2);

    // reset mid-fill
    push(10'd7, 19'd7);
    push(10'd8, 19'd8);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("rf_ready", bus.in_ready, 1'b1);
    chk("rf_pix", out_pixels, '0);
    chk("rf_wgt", out_weights, '0);
    chk("rf_busy", busy, 1'b0);
    for (int i = 0; i < N; i++) push(PW'(21 + i), WW'(31 + i));
    bus.in_valid = 1'b0;
    cyc(1);
    chk("rf_start", mac_start, 1'b1);
    chk("rf_pix2", out_pixels, {10'd24, 10'd23, 10'd22, 10'd21});
    chk("rf_wgt2", out_weights, {19'd34, 19'd33, 19'd32, 19'd31});

    // reset mid-run
    cyc(1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("rr_busy", busy, 1'b0);
    chk("rr_pix", out_pixels, '0);
    s0 = starts;
    cyc(8);
    chk("rr_no_start", starts - s0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
